// File: rtl/voting_pkg.sv
// Shared types and helpers for the multi-candidate voting machine.
package voting_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LOCKOUT = 1'b1
    } state_e;

    localparam logic MODE_VOTE  = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // Width of a candidate index; never narrower than one bit.
    function automatic int idx_w(input int num_cand);
        return (num_cand > 1) ? $clog2(num_cand) : 1;
    endfunction

endpackage

// File: rtl/voting_machine_multi_if.sv
// Button/mode inputs and LED/status outputs of the voting machine.
// Leader outputs exist only when VOTING_LEADER_EN is defined.
interface voting_machine_multi_if
    import voting_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    logic                mode;
    logic [NUM_CAND-1:0] button;
    logic [CNT_W-1:0]    led;
    logic                vote_pulse;
    logic                reject_pulse;
    logic                sat_flag;
`ifdef VOTING_LEADER_EN
    localparam int IDX_W = idx_w(NUM_CAND);
    logic [IDX_W-1:0]    leader_idx;
    logic                leader_tie;
`endif

    // Board side: drives buttons and mode, observes the LED bank.
    modport master (
        output mode, button,
        input  led, vote_pulse, reject_pulse, sat_flag
`ifdef VOTING_LEADER_EN
        , input leader_idx, leader_tie
`endif
    );

    // Machine side.
    modport slave (
        input  mode, button,
        output led, vote_pulse, reject_pulse, sat_flag
`ifdef VOTING_LEADER_EN
        , output leader_idx, leader_tie
`endif
    );

endinterface

// File: rtl/vote_debounce.sv
// Per-button debouncer: counts consecutive high samples, saturating at
// DEBOUNCE_CYC; any low sample restarts the count.
module vote_debounce #(
    parameter int DEBOUNCE_CYC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic stable_o
);
    localparam int             CW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_TOP = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear on low, hold at the top, otherwise step up
    always_comb begin
        if (!button_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TOP) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = (cnt_q == CNT_TOP);

endmodule

// File: rtl/voting_machine_multi.sv
// N-candidate voting machine: debounced buttons, one vote per press,
// saturating tallies, accept-indicator / tally display on the LED bank.
// Optional feature macro: VOTING_LEADER_EN adds leader_idx/leader_tie.
module voting_machine_multi
    import voting_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int LED_HOLD_CYC = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    voting_machine_multi_if.slave bus
);
    localparam int                 HOLD_W    = (LED_HOLD_CYC > 0) ? $clog2(LED_HOLD_CYC + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(LED_HOLD_CYC);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    logic [NUM_CAND-1:0] stable_s;
    logic [NUM_CAND-1:0] stable_prev_q;
    logic                mode_q;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    tally_q [NUM_CAND];
    logic [CNT_W-1:0]    tally_d [NUM_CAND];
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    led_q, led_d;
    logic                vote_q, vote_d;
    logic                rej_q, rej_d;
    logic                sat_q, sat_d;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
        vote_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .button_i (bus.button[g]),
            .stable_o (stable_s[g])
        );
    end

    // FSM next state, tally update, hold counter and LED selection
    always_comb begin
        state_d = state_q;
        tally_d = tally_q;
        hold_d  = hold_q;
        led_d   = led_q;
        vote_d  = 1'b0;
        rej_d   = 1'b0;
        sat_d   = sat_q;
        if (bus.mode != mode_q) begin
            // Mode switch: blank display and demand a full release first
            hold_d  = '0;
            led_d   = '0;
            state_d = LOCKOUT;
        end else if (bus.mode == MODE_VOTE) begin
            if (hold_q != '0) begin
                hold_d = hold_q - HOLD_ONE;
            end else begin
                hold_d = hold_q;
            end
            case (state_q)
                IDLE: begin
                    if ($onehot(stable_s)) begin
                        vote_d  = 1'b1;
                        hold_d  = HOLD_LOAD;
                        state_d = LOCKOUT;
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (stable_s[i]) begin
                                if (tally_q[i] == CNT_MAX) begin
                                    sat_d = 1'b1;
                                end else begin
                                    tally_d[i] = tally_q[i] + CNT_ONE;
                                end
                            end else begin
                                tally_d[i] = tally_q[i];
                            end
                        end
                    end else if (stable_s != '0) begin
                        rej_d   = 1'b1;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOCKOUT: begin
                    if (bus.button == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
                default: state_d = IDLE;
            endcase
            led_d = (hold_d != '0) ? CNT_MAX : '0;
        end else begin
            hold_d = '0;
            case (state_q)
                IDLE: begin
                    // Latch a tally only on a fresh, unambiguous press
                    if ($onehot(stable_s) && ((stable_s & ~stable_prev_q) != '0)) begin
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (stable_s[i]) begin
                                led_d = tally_q[i];
                            end else begin
                                led_d = led_d;
                            end
                        end
                    end else begin
                        led_d = led_q;
                    end
                end
                LOCKOUT: begin
                    if (bus.button == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, tallies and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mode_q        <= MODE_VOTE;
            stable_prev_q <= '0;
            hold_q        <= '0;
            led_q         <= '0;
            vote_q        <= 1'b0;
            rej_q         <= 1'b0;
            sat_q         <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            mode_q        <= bus.mode;
            stable_prev_q <= stable_s;
            hold_q        <= hold_d;
            led_q         <= led_d;
            vote_q        <= vote_d;
            rej_q         <= rej_d;
            sat_q         <= sat_d;
            tally_q       <= tally_d;
        end
    end

    assign bus.led          = led_q;
    assign bus.vote_pulse   = vote_q;
    assign bus.reject_pulse = rej_q;
    assign bus.sat_flag     = sat_q;

`ifdef VOTING_LEADER_EN
    localparam int IDX_W = idx_w(NUM_CAND);

    logic [IDX_W-1:0] lead_idx_q, lead_idx_d;
    logic             lead_tie_q, lead_tie_d;
    logic [CNT_W-1:0] lead_max_s;

    // Lowest-index maximum tally, and whether another candidate shares it
    always_comb begin
        lead_idx_d = '0;
        lead_max_s = tally_q[0];
        lead_tie_d = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally_q[i] > lead_max_s) begin
                lead_max_s = tally_q[i];
                lead_idx_d = IDX_W'(i);
            end else begin
                lead_max_s = lead_max_s;
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if ((IDX_W'(i) != lead_idx_d) && (tally_q[i] == lead_max_s) && (lead_max_s != '0)) begin
                lead_tie_d = 1'b1;
            end else begin
                lead_tie_d = lead_tie_d;
            end
        end
    end

    // Leader registers follow the tallies by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lead_idx_q <= '0;
            lead_tie_q <= 1'b0;
        end else begin
            lead_idx_q <= lead_idx_d;
            lead_tie_q <= lead_tie_d;
        end
    end

    assign bus.leader_idx = lead_idx_q;
    assign bus.leader_tie = lead_tie_q;
`endif

endmodule
